// File: rtl/sensor_pkg.sv
// Shared types and default constants for the sensor fault monitor.
package sensor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        QUAL  = 2'd1,
        FAULT = 2'd2
    } state_e;

    localparam int DEF_NUM_SENSORS = 4;
    localparam int DEF_PERSIST     = 3;
    localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/persist_counter.sv
// Qualification counter: counts consecutive fault cycles and flags the cycle
// on which the next increment would reach the persistence threshold.
module persist_counter #(
    parameter int PERSIST = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic match_o
);

    localparam logic [7:0] TERMINAL = 8'(PERSIST - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // With PERSIST==1 this is true from IDLE, so a fault is declared at once.
    assign match_o = (count_q == TERMINAL);

endmodule

// File: rtl/sensor_monitor.sv
// Sensor fault monitor: qualifies raw faults over PERSIST cycles, latches a
// sticky error with a sensor snapshot and counts error events.
module sensor_monitor
    import sensor_pkg::*;
#(
    parameter int                         NUM_SENSORS = DEF_NUM_SENSORS,
    parameter logic [NUM_SENSORS-1:0]     CRIT_MASK   = NUM_SENSORS'(1),
    parameter int                         PERSIST     = DEF_PERSIST,
    parameter int                         CNT_W       = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SENSORS-1:0] sensors,
    input  logic                   clear,
    output logic                   error,
    output logic                   pending,
    output logic [NUM_SENSORS-1:0] fault_code,
    output logic [CNT_W-1:0]       err_count
);

    if (NUM_SENSORS < 3 || NUM_SENSORS > 16) begin : g_badNumSensors
        $error("sensor_monitor: NUM_SENSORS must be 3..16");
    end
    if (PERSIST < 1 || PERSIST > 255) begin : g_badPersist
        $error("sensor_monitor: PERSIST must be 1..255");
    end

    state_e                 state_q, state_d;
    logic [NUM_SENSORS-1:0] faultCode_q, faultCode_d;
    logic [CNT_W-1:0]       errCount_q, errCount_d;
    logic                   rawFault;
    logic                   cntEnable;
    logic                   cntMatch;
    logic                   enterFault;

    // Critical sensors fault alone; sensor 1 faults only together with a higher one.
    assign rawFault = (|(sensors & CRIT_MASK)) |
                      (sensors[1] & (|sensors[NUM_SENSORS-1:2]));

    persist_counter #(
        .PERSIST (PERSIST)
    ) u_persistCounter (
        .clk_i    (clk),
        .rst_i    (rst),
        .clear_i  (!cntEnable),
        .enable_i (cntEnable),
        .match_o  (cntMatch)
    );

    always_comb begin
        state_d     = state_q;
        faultCode_d = faultCode_q;
        errCount_d  = errCount_q;
        cntEnable   = 1'b0;
        enterFault  = 1'b0;
        case (state_q)
            IDLE, QUAL: begin
                if (rawFault) begin
                    if (cntMatch) begin
                        enterFault = 1'b1;
                    end else begin
                        state_d   = QUAL;
                        cntEnable = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            FAULT: begin
                if (clear) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (enterFault) begin
            state_d     = FAULT;
            faultCode_d = sensors;
            if (errCount_q != '1) begin
                errCount_d = errCount_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            faultCode_q <= '0;
            errCount_q  <= '0;
        end else begin
            state_q     <= state_d;
            faultCode_q <= faultCode_d;
            errCount_q  <= errCount_d;
        end
    end

    assign error      = (state_q == FAULT);
    assign pending    = (state_q == QUAL);
    assign fault_code = faultCode_q;
    assign err_count  = errCount_q;

endmodule

// File: tb/tb_sensor_monitor.sv
// Scoreboard bench: two monitor instances (defaults, and PERSIST=1/CNT_W=2)
// driven with the same stimulus and compared against a behavioural model.
module tb_sensor_monitor;

    typedef struct {
        bit         latched;
        int         run;
        logic [3:0] code;
        int         count;
    } mdl_t;

    typedef struct {
        logic       err;
        logic       pend;
        logic [3:0] code;
        logic [7:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic [3:0] sensors = 4'h0;

    logic       errA, pendA, errB, pendB;
    logic [3:0] codeA, codeB;
    logic [7:0] cntA;
    logic [1:0] cntB;

    exp_t qA[$];
    exp_t qB[$];
    mdl_t mdlA = '{0, 0, 4'h0, 0};
    mdl_t mdlB = '{0, 0, 4'h0, 0};
    int   nChecks = 0;
    int   nFails  = 0;

    always #5 clk = ~clk;

    sensor_monitor #(
        .NUM_SENSORS (4),
        .CRIT_MASK   (4'b0001),
        .PERSIST     (3),
        .CNT_W       (8)
    ) dutA (
        .clk        (clk),
        .rst        (rst),
        .sensors    (sensors),
        .clear      (clear),
        .error      (errA),
        .pending    (pendA),
        .fault_code (codeA),
        .err_count  (cntA)
    );

    sensor_monitor #(
        .NUM_SENSORS (4),
        .CRIT_MASK   (4'b0001),
        .PERSIST     (1),
        .CNT_W       (2)
    ) dutB (
        .clk        (clk),
        .rst        (rst),
        .sensors    (sensors),
        .clear      (clear),
        .error      (errB),
        .pending    (pendB),
        .fault_code (codeB),
        .err_count  (cntB)
    );

    // Fault rule: sensor 0 alone, or sensor 1 together with sensor 2 or 3.
    function automatic bit rawOf(input logic [3:0] s);
        bit upper = 0;
        for (int i = 2; i < 4; i++) begin
            if (s[i]) upper = 1;
        end
        return (s[0] == 1'b1) || (s[1] == 1'b1 && upper);
    endfunction

    function automatic mdl_t step(input mdl_t m, input bit r, input logic [3:0] s,
                                  input bit c, input int persist, input int cmax);
        mdl_t n = m;
        if (r) begin
            n = '{0, 0, 4'h0, 0};
        end else if (m.latched) begin
            if (c) begin
                n.latched = 0;
                n.run     = 0;
            end
        end else if (rawOf(s)) begin
            n.run = m.run + 1;
            if (n.run >= persist) begin
                n.latched = 1;
                n.run     = 0;
                n.code    = s;
                n.count   = (m.count < cmax) ? m.count + 1 : cmax;
            end
        end else begin
            n.run = 0;
        end
        return n;
    endfunction

    function automatic exp_t toExp(input mdl_t m);
        exp_t e;
        e.err  = m.latched;
        e.pend = !m.latched && (m.run > 0);
        e.code = m.code;
        e.cnt  = 8'(m.count);
        return e;
    endfunction

    task automatic applyStimulus(input bit r, input logic [3:0] s, input bit c);
        @(negedge clk);
        rst     = r;
        sensors = s;
        clear   = c;
        mdlA = step(mdlA, r, s, c, 3, 255);
        mdlB = step(mdlB, r, s, c, 1, 3);
        qA.push_back(toExp(mdlA));
        qB.push_back(toExp(mdlB));
    endtask

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (qA.size() > 0) begin
                e = qA.pop_front();
                checkOutput("A.error",      {7'b0, errA},  {7'b0, e.err});
                checkOutput("A.pending",    {7'b0, pendA}, {7'b0, e.pend});
                checkOutput("A.fault_code", {4'b0, codeA}, {4'b0, e.code});
                checkOutput("A.err_count",  cntA,          e.cnt);
            end
            if (qB.size() > 0) begin
                e = qB.pop_front();
                checkOutput("B.error",      {7'b0, errB},  {7'b0, e.err});
                checkOutput("B.pending",    {7'b0, pendB}, {7'b0, e.pend});
                checkOutput("B.fault_code", {4'b0, codeB}, {4'b0, e.code});
                checkOutput("B.err_count",  {6'b0, cntB},  e.cnt);
            end
        end
    end

    initial begin : stimulus
        logic [3:0] s;
        int         len;
        applyStimulus(1, 4'h0, 0);
        applyStimulus(1, 4'h0, 1);
        // Critical sensor held three cycles, then idle and acknowledge.
        repeat (3) applyStimulus(0, 4'b0001, 0);
        repeat (2) applyStimulus(0, 4'b0000, 0);
        applyStimulus(0, 4'b0000, 1);
        applyStimulus(0, 4'b0000, 0);
        // Combination fault that drops out before qualifying; clear ignored in QUAL.
        applyStimulus(0, 4'b0110, 1);
        applyStimulus(0, 4'b0110, 0);
        repeat (2) applyStimulus(0, 4'b0000, 0);
        // Held fault, clear while still faulty: requalification restarts.
        repeat (4) applyStimulus(0, 4'b1010, 0);
        applyStimulus(0, 4'b1010, 1);
        repeat (5) applyStimulus(0, 4'b1010, 0);
        applyStimulus(0, 4'b0000, 1);
        // Non-qualifying single upper sensors.
        repeat (10) applyStimulus(0, 4'b0100, 0);
        repeat (10) applyStimulus(0, 4'b1000, 0);
        // Reset mid-qualification and while faulted.
        repeat (2) applyStimulus(0, 4'b0001, 0);
        applyStimulus(1, 4'b0001, 1);
        applyStimulus(0, 4'b0000, 0);
        repeat (4) applyStimulus(0, 4'b0001, 0);
        applyStimulus(1, 4'b0001, 1);
        // Clear coinciding with the qualifying edge.
        applyStimulus(0, 4'b0011, 0);
        applyStimulus(0, 4'b0011, 0);
        applyStimulus(0, 4'b0011, 1);
        applyStimulus(0, 4'b0000, 1);
        // Four faults with clears: saturation on the narrow counter.
        repeat (4) begin
            repeat (3) applyStimulus(0, 4'b0001, 0);
            applyStimulus(0, 4'b0000, 1);
            applyStimulus(0, 4'b0000, 0);
        end
        // Randomised held patterns with occasional clear and reset.
        repeat (80) begin
            s   = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            len = $urandom_range(1, 5);
            for (int k = 0; k < len; k++) begin
                applyStimulus($urandom_range(0, 60) == 0, s, $urandom_range(0, 4) == 0);
            end
        end
        @(posedge clk);
        #3;
        checkOutput("queueA.drained", 8'(qA.size()), 8'd0);
        checkOutput("queueB.drained", 8'(qB.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/sensor_monitor.md
SENSOR_MONITOR -- requirements
Module: sensor_monitor

Interface
REQ-001 Parameter NUM_SENSORS, default 4, meaning number of sensor inputs; the legal range SHALL be 3..16.
REQ-002 Parameter CRIT_MASK, default 'b0001 (NUM_SENSORS bits), meaning sensors that fault on their own when asserted.
REQ-003 Parameter PERSIST, default 3, meaning consecutive raw-fault cycles required to declare an error; the legal range SHALL be 1..255.
REQ-004 Parameter CNT_W, default 8, meaning width of the error-event counter.
REQ-005 Port clk  input  1  clock; all state SHALL update on the rising edge.
REQ-006 Port rst  input  1  reset; synchronous, active-high.
REQ-007 Port sensors  input  NUM_SENSORS  raw sensor levels, synchronous to clk.
REQ-008 Port clear  input  1  single-cycle request to acknowledge and clear a latched error.
REQ-009 Port error  output  1  registered, sticky error flag.
REQ-010 Port pending  output  1  high while a raw fault is being qualified.
REQ-011 Port fault_code  output  NUM_SENSORS  sensors snapshot captured when error sets.
REQ-012 Port err_count  output  CNT_W  saturating count of error events since reset.

Function
REQ-013 raw_fault SHALL be combinational: (any bit of sensors & CRIT_MASK) OR (sensors[1] AND any of sensors[NUM_SENSORS-1:2]).
REQ-014 The FSM SHALL have states IDLE, QUAL and FAULT; the output pending SHALL equal (state==QUAL) and the output error SHALL equal (state==FAULT), both registered.
REQ-015 IDLE: on raw_fault the FSM SHALL go to QUAL with persistence counter = 1, or directly to FAULT if PERSIST==1.
REQ-016 QUAL: while raw_fault holds, the counter SHALL increment each cycle; once the counter equals PERSIST, the FSM SHALL enter FAULT.
REQ-017 QUAL: if raw_fault drops before the counter reaches PERSIST, the FSM SHALL return to IDLE and clear the counter (no error, err_count unchanged).
REQ-018 Latency: with raw_fault continuously high from cycle 0, error SHALL first read 1 after edge PERSIST (the edge that ends cycle PERSIST-1).
REQ-019 On entry to FAULT, fault_code SHALL capture the sensors value on that edge, and err_count SHALL increment by 1, saturating at 2^CNT_W-1.
REQ-020 FAULT: state SHALL persist regardless of sensors until clear==1; fault_code SHALL hold its value.
REQ-021 clear in FAULT SHALL move to IDLE next edge; fault_code SHALL hold its value, and err_count SHALL be unchanged.
REQ-022 If raw_fault is still present after a clear, qualification SHALL restart from IDLE on the following cycle (full PERSIST again).
REQ-023 clear in IDLE or QUAL SHALL be ignored.
REQ-024 clear and entry condition on the same edge in QUAL: the FSM SHALL enter FAULT (clear is ignored).

Reset
REQ-025 When rst==1 at an edge, the FSM SHALL go to IDLE and the persistence counter SHALL be 0.
REQ-026 Reset values: error=0, pending=0, fault_code=0, err_count=0.
REQ-027 Reset SHALL take priority over clear and sensors, including mid-QUAL and in FAULT.

Structure
REQ-028 Package sensor_pkg SHALL hold the state enum (IDLE, QUAL, FAULT) and the default constants for NUM_SENSORS, PERSIST and CNT_W.
REQ-029 A sub-module persist_counter (clear, enable, count, terminal-match flag) SHALL implement the qualification counter.
REQ-030 raw_fault decode SHALL stay in sensor_monitor.

Verification
REQ-031 Defaults; sensors=0001 held 3 cycles -> error=1 after the 3rd edge, fault_code=0001, err_count=1.
REQ-032 sensors=0110 for 2 cycles then 0000 -> pending high 2 cycles, error stays 0, err_count=0.
REQ-033 FAULT with sensors=1010 held, pulse clear -> error=0 next edge; pending=1 on the following edge; error=1 again 3 edges later; err_count=2.
REQ-034 sensors=0100 or 1000 alone, 10 cycles -> error=0, pending=0 throughout.
REQ-035 rst asserted in QUAL (count=2) and in FAULT -> all outputs reach their reset values on the next edge.
REQ-036 CNT_W=2; four faults each followed by a clear -> err_count goes 1,2,3,3.
